// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: waits on variable-latency loads, aligns load data and registers the write-back/bypass triple.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output retire_cnt_o.
module mem_wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 flush_i,
  output logic                 in_ready_o,
  input  logic [31:0]          pc_plus4_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic                 reg_wr_en_i,
  input  logic [1:0]           src_to_reg_i,
  input  logic                 mem_rd_en_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          dmem_rdata_i,
  input  logic                 dmem_rvalid_i,
  output logic [XLEN-1:0]      mem_wb_data,
  output logic [RF_ADDR_W-1:0] mem_wb_rd,
  output logic                 ireg_mem_wb_wr,
  output logic                 wb_valid_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]          retire_cnt_o
`endif
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic [RF_ADDR_W-1:0]   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   wbv_q, wbv_d;

  logic [RF_ADDR_W-1:0]   h_rd_q, h_rd_d;
  logic                   h_wr_q, h_wr_d;
  logic [2:0]             h_f3_q, h_f3_d;
  logic [1:0]             h_src_q, h_src_d;
  logic [XLEN-1:0]        h_alu_q, h_alu_d;
  logic [31:0]            h_pc_q, h_pc_d;

  logic                   accept;
  logic                   complete;
  logic [RF_ADDR_W-1:0]   sel_rd;
  logic                   sel_wr;
  logic [2:0]             sel_f3;
  logic [1:0]             sel_src;
  logic [XLEN-1:0]        sel_alu;
  logic [31:0]            sel_pc;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [XLEN-1:0]        load_val;
  logic [XLEN-1:0]        wb_src;

  assign in_ready_o = (state_q == ST_RUN);
  assign accept     = valid_i & ~flush_i & (state_q == ST_RUN);

  // A completing WAIT uses the captured instruction, not whatever upstream presents now.
  always_comb begin
    if (state_q == ST_WAIT) begin
      sel_rd  = h_rd_q;
      sel_wr  = h_wr_q;
      sel_f3  = h_f3_q;
      sel_src = h_src_q;
      sel_alu = h_alu_q;
      sel_pc  = h_pc_q;
    end else begin
      sel_rd  = rd_i;
      sel_wr  = reg_wr_en_i;
      sel_f3  = funct3_i;
      sel_src = src_to_reg_i;
      sel_alu = alu_result_i;
      sel_pc  = pc_plus4_i;
    end
  end

  always_comb begin
    unique case (sel_alu[1:0])
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = sel_alu[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (sel_f3)
      3'b000:  load_val = XLEN'($signed(byte_sel));
      3'b100:  load_val = XLEN'(byte_sel);
      3'b001:  load_val = XLEN'($signed(half_sel));
      3'b101:  load_val = XLEN'(half_sel);
      default: load_val = XLEN'(dmem_rdata_i);
    endcase
    unique case (sel_src)
      2'b01:   wb_src = load_val;
      2'b10:   wb_src = XLEN'(sel_pc);
      default: wb_src = sel_alu;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rd_d     = rd_q;
    wr_d     = 1'b0;
    wbv_d    = 1'b0;
    h_rd_d   = h_rd_q;
    h_wr_d   = h_wr_q;
    h_f3_d   = h_f3_q;
    h_src_d  = h_src_q;
    h_alu_d  = h_alu_q;
    h_pc_d   = h_pc_q;
    complete = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (mem_rd_en_i && !dmem_rvalid_i) begin
            h_rd_d  = rd_i;
            h_wr_d  = reg_wr_en_i;
            h_f3_d  = funct3_i;
            h_src_d = src_to_reg_i;
            h_alu_d = alu_result_i;
            h_pc_d  = pc_plus4_i;
            state_d = ST_WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      default: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          state_d  = ST_RUN;
        end
      end
    endcase
    if (complete) begin
      data_d = wb_src;
      rd_d   = sel_rd;
      wr_d   = sel_wr & (sel_rd != '0);
      wbv_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      data_q  <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      wbv_q   <= 1'b0;
      h_rd_q  <= '0;
      h_wr_q  <= 1'b0;
      h_f3_q  <= '0;
      h_src_q <= '0;
      h_alu_q <= '0;
      h_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wbv_q   <= wbv_d;
      h_rd_q  <= h_rd_d;
      h_wr_q  <= h_wr_d;
      h_f3_q  <= h_f3_d;
      h_src_q <= h_src_d;
      h_alu_q <= h_alu_d;
      h_pc_q  <= h_pc_d;
    end
  end

  assign mem_wb_data    = data_q;
  assign mem_wb_rd      = rd_q;
  assign ireg_mem_wb_wr = wr_q;
  assign wb_valid_o     = wbv_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {63'd0, wbv_q};
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; retire counter checks compile in with WB_RETIRE_CNT_EN.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] pc_plus4_i = '0;
  logic [31:0] alu_result_i = '0;
  logic [4:0]  rd_i = '0;
  logic        reg_wr_en_i = 1'b0;
  logic [1:0]  src_to_reg_i = '0;
  logic        mem_rd_en_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        ireg_mem_wb_wr;
  logic        wb_valid_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  mem_wb_stage #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .CLK(CLK), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .in_ready_o(in_ready_o),
    .pc_plus4_i(pc_plus4_i), .alu_result_i(alu_result_i), .rd_i(rd_i), .reg_wr_en_i(reg_wr_en_i),
    .src_to_reg_i(src_to_reg_i), .mem_rd_en_i(mem_rd_en_i), .funct3_i(funct3_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i), .mem_wb_data(mem_wb_data),
    .mem_wb_rd(mem_wb_rd), .ireg_mem_wb_wr(ireg_mem_wb_wr), .wb_valid_o(wb_valid_o)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt_o(retire_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; mem_rd_en_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic issue(input logic [1:0] src, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic [2:0] f3,
                       input logic [31:0] rdata, input logic rv);
    valid_i = 1'b1; flush_i = 1'b0; src_to_reg_i = src; alu_result_i = alu; pc_plus4_i = pc;
    rd_i = rd; reg_wr_en_i = wr; mem_rd_en_i = ld; funct3_i = f3; dmem_rdata_i = rdata;
    dmem_rvalid_i = rv;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    #3;
    checks++; if (mem_wb_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=%h", mem_wb_data, 32'h0); end
    checks++; if (mem_wb_rd !== 5'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", mem_wb_rd); end
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b exp=0", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wbv got=%b exp=0", wb_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready_o); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_back_to_back();
    issue(2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);
    step();
    checks++; if (mem_wb_data !== 32'h1234) begin failures++; $display("FAIL add_data got=%h exp=%h", mem_wb_data, 32'h1234); end
    checks++; if (mem_wb_rd !== 5'd5) begin failures++; $display("FAIL add_rd got=%0d exp=5", mem_wb_rd); end
    checks++; if (ireg_mem_wb_wr !== 1'b1) begin failures++; $display("FAIL add_wr got=%b exp=1", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL add_wbv got=%b exp=1", wb_valid_o); end
    issue(2'b11, 32'hCAFE_0001, 32'h0, 5'd6, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);
    step();
    checks++; if (mem_wb_data !== 32'hCAFE_0001) begin failures++; $display("FAIL b2b_data got=%h exp=%h", mem_wb_data, 32'hCAFE_0001); end
    checks++; if (mem_wb_rd !== 5'd6) begin failures++; $display("FAIL b2b_rd got=%0d exp=6", mem_wb_rd); end
    checks++; if (ireg_mem_wb_wr !== 1'b1) begin failures++; $display("FAIL b2b_wr got=%b exp=1", ireg_mem_wb_wr); end
    idle_inputs();
    dmem_rvalid_i = 1'b1;
    step();
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL idle_wr got=%b exp=0", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL idle_wbv got=%b exp=0", wb_valid_o); end
    checks++; if (mem_wb_data !== 32'hCAFE_0001) begin failures++; $display("FAIL idle_hold got=%h exp=%h", mem_wb_data, 32'hCAFE_0001); end
    idle_inputs();
  endtask

  task automatic test_load_align();
    issue(2'b01, 32'h0000_0002, 32'h0, 5'd7, 1'b1, 1'b1, 3'b000, 32'h0080_0000, 1'b1);
    step();
    checks++; if (mem_wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=%h", mem_wb_data, 32'hFFFF_FF80); end
    checks++; if (ireg_mem_wb_wr !== 1'b1) begin failures++; $display("FAIL lb_wr got=%b exp=1", ireg_mem_wb_wr); end
    checks++; if (mem_wb_rd !== 5'd7) begin failures++; $display("FAIL lb_rd got=%0d exp=7", mem_wb_rd); end
    funct3_i = 3'b100;
    step();
    checks++; if (mem_wb_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=%h", mem_wb_data, 32'h0000_0080); end
    issue(2'b01, 32'h0000_0003, 32'h0, 5'd8, 1'b1, 1'b1, 3'b000, 32'h7F12_3456, 1'b1);
    step();
    checks++; if (mem_wb_data !== 32'h0000_007F) begin failures++; $display("FAIL lb3_data got=%h exp=%h", mem_wb_data, 32'h0000_007F); end
    issue(2'b01, 32'h0000_0001, 32'h0, 5'd8, 1'b1, 1'b1, 3'b101, 32'h1234_F00D, 1'b1);
    step();
    checks++; if (mem_wb_data !== 32'h0000_F00D) begin failures++; $display("FAIL lhu_data got=%h exp=%h", mem_wb_data, 32'h0000_F00D); end
    funct3_i = 3'b001; alu_result_i = 32'h0000_0000;
    step();
    checks++; if (mem_wb_data !== 32'hFFFF_F00D) begin failures++; $display("FAIL lh0_data got=%h exp=%h", mem_wb_data, 32'hFFFF_F00D); end
    funct3_i = 3'b010;
    step();
    checks++; if (mem_wb_data !== 32'h1234_F00D) begin failures++; $display("FAIL lw_data got=%h exp=%h", mem_wb_data, 32'h1234_F00D); end
    funct3_i = 3'b011; alu_result_i = 32'h0000_0003;
    step();
    checks++; if (mem_wb_data !== 32'h1234_F00D) begin failures++; $display("FAIL f3_011_data got=%h exp=%h", mem_wb_data, 32'h1234_F00D); end
    idle_inputs();
    step();
  endtask

  task automatic test_load_wait();
    issue(2'b01, 32'h0000_1002, 32'h0, 5'd9, 1'b1, 1'b1, 3'b001, 32'h8001_0000, 1'b0);
    step();
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL wait1_ready got=%b exp=0", in_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL wait1_wbv got=%b exp=0", wb_valid_o); end
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL wait1_wr got=%b exp=0", ireg_mem_wb_wr); end
    issue(2'b00, 32'h0000_DEAD, 32'h0, 5'd3, 1'b1, 1'b0, 3'b100, 32'h1111_1111, 1'b0);
    flush_i = 1'b1;
    step();
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL wait2_ready got=%b exp=0", in_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL wait2_wbv got=%b exp=0", wb_valid_o); end
    flush_i = 1'b0;
    step();
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL wait3_ready got=%b exp=0", in_ready_o); end
    dmem_rdata_i = 32'h8001_5555; dmem_rvalid_i = 1'b1; flush_i = 1'b1;
    step();
    checks++; if (mem_wb_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lhwait_data got=%h exp=%h", mem_wb_data, 32'hFFFF_8001); end
    checks++; if (mem_wb_rd !== 5'd9) begin failures++; $display("FAIL lhwait_rd got=%0d exp=9", mem_wb_rd); end
    checks++; if (ireg_mem_wb_wr !== 1'b1) begin failures++; $display("FAIL lhwait_wr got=%b exp=1", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL lhwait_wbv got=%b exp=1", wb_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL lhwait_ready got=%b exp=1", in_ready_o); end
    idle_inputs();
    step();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL lhwait_after_wbv got=%b exp=0", wb_valid_o); end
    checks++; if (mem_wb_rd !== 5'd9) begin failures++; $display("FAIL lhwait_after_rd got=%0d exp=9", mem_wb_rd); end
  endtask

  task automatic test_jal_x0_flush();
    issue(2'b10, 32'h0000_0055, 32'h0000_0104, 5'd0, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
    step();
    checks++; if (mem_wb_data !== 32'h0000_0104) begin failures++; $display("FAIL jal_data got=%h exp=%h", mem_wb_data, 32'h0000_0104); end
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL jal_x0_wr got=%b exp=0", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL jal_wbv got=%b exp=1", wb_valid_o); end
    issue(2'b00, 32'h0000_0999, 32'h0, 5'd4, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
    flush_i = 1'b1;
    step();
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL flush_wr got=%b exp=0", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL flush_wbv got=%b exp=0", wb_valid_o); end
    checks++; if (mem_wb_data !== 32'h0000_0104) begin failures++; $display("FAIL flush_hold got=%h exp=%h", mem_wb_data, 32'h0000_0104); end
    checks++; if (mem_wb_rd !== 5'd0) begin failures++; $display("FAIL flush_rd got=%0d exp=0", mem_wb_rd); end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    issue(2'b00, 32'h0000_7777, 32'h0, 5'd12, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
    step();
    issue(2'b01, 32'h0000_0000, 32'h0, 5'd11, 1'b1, 1'b1, 3'b010, 32'hABCD_0123, 1'b0);
    step();
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rw_ready_pre got=%b exp=0", in_ready_o); end
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_wb_data !== 32'h0) begin failures++; $display("FAIL rw_data got=%h exp=%h", mem_wb_data, 32'h0); end
    checks++; if (mem_wb_rd !== 5'd0) begin failures++; $display("FAIL rw_rd got=%0d exp=0", mem_wb_rd); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rw_ready got=%b exp=1", in_ready_o); end
    #2 rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    step();
    checks++; if (ireg_mem_wb_wr !== 1'b0) begin failures++; $display("FAIL rw_late_wr got=%b exp=0", ireg_mem_wb_wr); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rw_late_wbv got=%b exp=0", wb_valid_o); end
    idle_inputs();
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    rst = 1'b1; idle_inputs();
    #2;
    checks++; if (retire_cnt_o !== 64'd0) begin failures++; $display("FAIL cnt_rst got=%0d exp=0", retire_cnt_o); end
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 32'h100 + i, 32'h0, 5'd1, 1'b1, 1'b0, 3'b000, 32'h0, 1'b0);
      step();
    end
    flush_i = 1'b1;
    step();
    issue(2'b01, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 3'b010, 32'h5, 1'b0);
    step();
    idle_inputs();
    dmem_rvalid_i = 1'b1;
    step();
    idle_inputs();
    step();
    checks++; if (retire_cnt_o !== 64'd5) begin failures++; $display("FAIL cnt_total got=%0d exp=5", retire_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_align();
    test_load_wait();
    test_jal_x0_flush();
    test_reset_in_wait();
`ifdef WB_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/write-back pipeline stage. Accepts one retiring instruction per cycle from the EX/MEM boundary.
- Waits on a variable-latency data-memory load response, then aligns and sign-extends the load data.
- Selects the write-back source and drives the registered write-back/bypass triple: mem_wb_data, mem_wb_rd, ireg_mem_wb_wr. The register file and the ID/EX bypass mux consume this triple.
- Producer end of the write-back forwarding interface.

Parameters:
XLEN, 32, data width of the write-back path.
RF_ADDR_W, 5, register index width.

Ports:
CLK  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
valid_i  in  1  EX/MEM instruction valid.
flush_i  in  1  kills the instruction presented this cycle (treated as bubble).
in_ready_o  out  1  stage can accept; upstream holds all inputs while low.
pc_plus4_i  in  32  return address for JAL/JALR.
alu_result_i  in  XLEN  ALU result; bits [1:0] are the load byte offset.
rd_i  in  RF_ADDR_W  destination register.
reg_wr_en_i  in  1  instruction writes rd.
src_to_reg_i  in  2  write-back source select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
mem_rd_en_i  in  1  instruction is a load.
funct3_i  in  3  load type.
dmem_rdata_i  in  32  raw word from data memory.
dmem_rvalid_i  in  1  load data valid (may coincide with issue).
mem_wb_data  out  XLEN  write-back data.
mem_wb_rd  out  RF_ADDR_W  write-back register index.
ireg_mem_wb_wr  out  1  register-file write strobe; also the bypass enable.
wb_valid_o  out  1  one instruction retired this cycle.

Behaviour:
- Reset (async, rst=1): state=RUN; mem_wb_data=0, mem_wb_rd=0, ireg_mem_wb_wr=0, wb_valid_o=0; hold registers cleared; in_ready_o=1 once state is RUN. A load pending in WAIT is dropped.
- accept = valid_i & !flush_i & (state==RUN).
- in_ready_o = (state==RUN). Purely combinational from state.
- FSM state RUN:
  - Non-load accepted: complete at this edge (latency 1).
  - Load accepted with dmem_rvalid_i=1 the same cycle: complete at this edge.
  - Load accepted with dmem_rvalid_i=0: latch rd, reg_wr_en, funct3, offset and src_to_reg into hold registers; go to WAIT. ireg_mem_wb_wr and wb_valid_o drive 0 next cycle.
  - No accept: ireg_mem_wb_wr=0, wb_valid_o=0; mem_wb_data and mem_wb_rd hold.
- FSM state WAIT:
  - flush_i is ignored (the pending load is older than any flushing instruction).
  - Valid inputs are not accepted.
  - On dmem_rvalid_i=1: complete using the hold registers; return to RUN. in_ready_o goes 1 the next cycle; no same-cycle accept.
- Complete (registered at the edge):
  - mem_wb_data <= selected source.
  - mem_wb_rd <= rd.
  - ireg_mem_wb_wr <= reg_wr_en & (rd!=0).
  - wb_valid_o <= 1.
  - Strobes are single-cycle pulses.
- Load alignment, with offset = alu_result[1:0]:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[1] (offset[0] ignored), sign-extended.
  - 101 LHU: halfword at offset[1], zero-extended.
  - 010 LW: full word.
  - Other encodings: full word.
- dmem_rvalid_i in RUN with no load accepted is ignored.
- Write to x0: data and rd are still updated; write strobe stays 0; wb_valid_o=1.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: adds output retire_cnt_o [63:0]. Reset to 0; increments by 1 on every cycle wb_valid_o is 1; wraps from all-ones to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then ADD: valid_i=1, src=00, alu=0x0000_1234, rd=5, wr_en=1 -> next cycle mem_wb_data=0x1234, mem_wb_rd=5, ireg_mem_wb_wr=1, wb_valid_o=1. Strobe 0 the following idle cycle.
2. LB, zero-latency: alu[1:0]=2, dmem_rdata=0x00_80_00_00, rvalid same cycle, rd=7 -> mem_wb_data=0xFFFF_FF80, strobe=1. Repeat as LBU -> 0x0000_0080.
3. LH, 3-cycle memory: issue with rvalid=0, offset=2, rdata=0x8001_xxxx -> in_ready_o=0 for 3 cycles while inputs change (ignored). Cycle after rvalid: data=0xFFFF_8001, state returns to RUN.
4. JAL write to x0 and flush: src=10, pc_plus4=0x104, rd=0 -> data=0x104, strobe=0, wb_valid_o=1. Next instruction with flush_i=1 -> no strobe, outputs hold.
5. Reset in WAIT: assert rst while waiting on a load -> all outputs 0 immediately, in_ready_o=1. A late rvalid after reset produces no write.
6. With WB_RETIRE_CNT_EN: 4 retirements, 1 flushed instruction, 1 stalled load -> retire_cnt_o=5 after the load returns.
